// File: rtl/ser_frame_scheduler.sv
// rtl/ser_frame_scheduler.sv - serial start-pattern hunter that gates fixed-length payload frames
// Frames are separated by a dead gap; bits from before or inside a frame never feed a later match.
module ser_frame_scheduler #(
  parameter int                 PAT_LEN = 6,
  parameter logic [PAT_LEN-1:0] PATTERN = 6'b011110,
  parameter int                 CNT_W   = 10,
  parameter int                 GAP_LEN = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             serIn,
  input  logic [CNT_W-1:0] win_len,
  output logic             serOut,
  output logic             serOutValid,
  output logic             busy,
  output logic             frame_done,
  output logic [7:0]       frame_cnt
);

  typedef enum logic [1:0] {IDLE, HUNT, PAYLOAD, GAP} state_t;

  state_t             state, state_nx;
  logic [PAT_LEN-1:0] hist, hist_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [7:0]         gap_cnt, gap_cnt_nx;
  logic               out_nx, valid_nx, done_nx;
  logic               match;

  assign match = ({hist[PAT_LEN-2:0], serIn} == PATTERN);
  assign busy  = (state == PAYLOAD) || (state == GAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      hist        <= '0;
      cnt         <= '0;
      gap_cnt     <= '0;
      serOut      <= 1'b0;
      serOutValid <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      state       <= state_nx;
      hist        <= hist_nx;
      cnt         <= cnt_nx;
      gap_cnt     <= gap_cnt_nx;
      serOut      <= out_nx;
      serOutValid <= valid_nx;
      frame_done  <= done_nx;
      if (done_nx && (frame_cnt != 8'hFF))
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // A captured length of 0 decrements through all-ones, giving 2^CNT_W payload edges.
  always_comb begin
    state_nx   = state;
    hist_nx    = hist;
    cnt_nx     = cnt;
    gap_cnt_nx = gap_cnt;
    out_nx     = 1'b0;
    valid_nx   = 1'b0;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        hist_nx = '0;
        if (enable)
          state_nx = HUNT;
      end
      HUNT: begin
        if (!enable) begin
          state_nx = IDLE;
          hist_nx  = '0;
        end else begin
          hist_nx = {hist[PAT_LEN-2:0], serIn};
          if (match) begin
            state_nx = PAYLOAD;
            cnt_nx   = win_len;
          end
        end
      end
      PAYLOAD: begin
        out_nx   = serIn;
        valid_nx = 1'b1;
        cnt_nx   = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          done_nx    = 1'b1;
          state_nx   = GAP;
          gap_cnt_nx = 8'(GAP_LEN);
        end
      end
      GAP: begin
        hist_nx    = '0;
        gap_cnt_nx = gap_cnt - 8'd1;
        if (gap_cnt == 8'd1)
          state_nx = enable ? HUNT : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ser_frame_scheduler.sv
// tb/tb_ser_frame_scheduler.sv - self-checking bench for ser_frame_scheduler
// Expected outputs come from a frame-level model that scans the input bit stream.
module tb_ser_frame_scheduler;

  localparam int         PL  = 6;
  localparam logic [5:0] PAT = 6'b011110;
  localparam int         CW  = 4;
  localparam int         GL  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          serIn;
  logic [CW-1:0] win_len;
  logic          serOut, serOutValid, busy, frame_done;
  logic [7:0]    frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bit            en_q[$];
  bit            din_q[$];
  logic [CW-1:0] wl_q[$];
  logic [11:0]   exp_q[$];
  logic [11:0]   obs_q[$];

  ser_frame_scheduler #(.PAT_LEN(PL), .PATTERN(PAT), .CNT_W(CW), .GAP_LEN(GL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .serIn(serIn), .win_len(win_len),
    .serOut(serOut), .serOutValid(serOutValid), .busy(busy),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Observation word: {busy, frame_done, serOutValid, serOut, frame_cnt}
  function automatic void build_expected();
    int n = din_q.size();
    int t = 0;
    int hs = 0;
    int nlen, w, lo, fc;
    bit hunting = 0;
    logic [11:0] e[];
    e = new[n];
    foreach (e[i]) e[i] = '0;
    while (t < n) begin
      if (!hunting) begin
        if (en_q[t]) begin hunting = 1; hs = t + 1; end
        t++;
      end else if (!en_q[t]) begin
        hunting = 0;
        t++;
      end else begin
        w  = 0;
        lo = (t - PL + 1 > hs) ? t - PL + 1 : hs;
        for (int i = lo; i <= t; i++) w = (w << 1) | int'(din_q[i]);
        if (w == int'(PAT)) begin
          nlen = (wl_q[t] == 0) ? (1 << CW) : int'(wl_q[t]);
          for (int k = 0; k < nlen + GL; k++)
            if (t + k < n) e[t+k][11] = 1'b1;
          for (int k = 1; k <= nlen; k++)
            if (t + k < n) begin e[t+k][9] = 1'b1; e[t+k][8] = din_q[t+k]; end
          if (t + nlen < n) e[t+nlen][10] = 1'b1;
          if (t + nlen + GL < n) hunting = en_q[t+nlen+GL];
          hs = t + nlen + GL + 1;
          t  = t + nlen + GL + 1;
        end else begin
          t++;
        end
      end
    end
    fc = 0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      if (e[i][10] && fc < 255) fc++;
      e[i][7:0] = 8'(fc);
      exp_q.push_back(e[i]);
    end
  endfunction

  task automatic clear_stim();
    en_q.delete(); din_q.delete(); wl_q.delete();
  endtask

  task automatic push(input bit e, input bit d, input logic [CW-1:0] w);
    en_q.push_back(e); din_q.push_back(d); wl_q.push_back(w);
  endtask

  task automatic push_bits(input bit e, input logic [5:0] bits, input logic [CW-1:0] w);
    logic [5:0] b;
    b = bits;
    for (int i = 5; i >= 0; i--) push(e, b[i], w);
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; serIn = 1'b0; win_len = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_all();
    obs_q.delete();
    for (int t = 0; t < en_q.size(); t++) begin
      enable = en_q[t]; serIn = din_q[t]; win_len = wl_q[t];
      @(posedge clk); #2;
      obs_q.push_back({busy, frame_done, serOutValid, serOut, frame_cnt});
      @(negedge clk);
    end
  endtask

  function automatic int count_bit(input int pos);
    int c = 0;
    foreach (obs_q[i]) if (obs_q[i][pos]) c++;
    return c;
  endfunction

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if ({busy, frame_done, serOutValid, serOut, frame_cnt} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", {busy, frame_done, serOutValid, serOut, frame_cnt}, 12'h000);
    end
  endtask

  task automatic test_basic_frame();
    logic [3:0] got;
    int k;
    do_reset(); clear_stim();
    push(1, 0, 4);
    push_bits(1, 6'b011110, 4);
    push(1, 1, 7); push(1, 0, 7); push(1, 1, 7); push(1, 1, 7);
    push(1, 0, 7); push(1, 0, 7);
    push_bits(1, 6'b011100, 7);
    repeat (4) push(1, 0, 7);
    build_expected(); drive_all();
    for (int t = 0; t < obs_q.size(); t++) begin
      n_checks++;
      if (obs_q[t] !== exp_q[t]) begin
        n_fail++;
        $display("FAIL basic_frame cycle %0d: got %b expected %b", t, obs_q[t], exp_q[t]);
      end
    end
    got = '0; k = 0;
    foreach (obs_q[i]) if (obs_q[i][9] && k < 4) begin got = {got[2:0], obs_q[i][8]}; k++; end
    n_checks++;
    if (got !== 4'b1011 || count_bit(9) != 4) begin
      n_fail++;
      $display("FAIL basic_payload: got %b (%0d bits) expected 1011 (4 bits)", got, count_bit(9));
    end
    n_checks++;
    if (frame_cnt !== 8'd1 || count_bit(10) != 1) begin
      n_fail++;
      $display("FAIL basic_count: got cnt %0d done %0d expected cnt 1 done 1", frame_cnt, count_bit(10));
    end
  endtask

  task automatic test_gap_pattern();
    do_reset(); clear_stim();
    push(1, 0, 3);
    push_bits(1, 6'b011110, 3);
    push(1, 1, 9); push(1, 0, 9); push(1, 1, 9);
    push_bits(1, 6'b011110, 9);
    push_bits(1, 6'b011110, 2);
    push(1, 1, 5); push(1, 1, 5);
    repeat (4) push(1, 0, 5);
    build_expected(); drive_all();
    for (int t = 0; t < obs_q.size(); t++) begin
      n_checks++;
      if (obs_q[t] !== exp_q[t]) begin
        n_fail++;
        $display("FAIL gap_pattern cycle %0d: got %b expected %b", t, obs_q[t], exp_q[t]);
      end
    end
    n_checks++;
    if (count_bit(10) != 2) begin
      n_fail++;
      $display("FAIL gap_pattern frames: got %0d expected 2", count_bit(10));
    end
  endtask

  task automatic test_zero_len();
    do_reset(); clear_stim();
    push(1, 0, 5);
    push_bits(1, 6'b011110, 0);
    repeat (16) push(1, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)));
    repeat (6) push(1, 0, 3);
    build_expected(); drive_all();
    for (int t = 0; t < obs_q.size(); t++) begin
      n_checks++;
      if (obs_q[t] !== exp_q[t]) begin
        n_fail++;
        $display("FAIL zero_len cycle %0d: got %b expected %b", t, obs_q[t], exp_q[t]);
      end
    end
    n_checks++;
    if (count_bit(9) != 16 || count_bit(10) != 1) begin
      n_fail++;
      $display("FAIL zero_len counts: got valid %0d done %0d expected valid 16 done 1", count_bit(9), count_bit(10));
    end
  endtask

  task automatic test_enable_drop();
    do_reset(); clear_stim();
    push(1, 0, 8);
    push_bits(1, 6'b011110, 8);
    push(1, 1, 8);
    repeat (7) push(0, 1'($urandom_range(0, 1)), 8);
    repeat (4) push(0, 0, 8);
    push_bits(0, 6'b011110, 2);
    repeat (4) push(0, 0, 2);
    build_expected(); drive_all();
    for (int t = 0; t < obs_q.size(); t++) begin
      n_checks++;
      if (obs_q[t] !== exp_q[t]) begin
        n_fail++;
        $display("FAIL enable_drop cycle %0d: got %b expected %b", t, obs_q[t], exp_q[t]);
      end
    end
    n_checks++;
    if (count_bit(9) != 8 || count_bit(10) != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_drop counts: got valid %0d done %0d busy %b expected 8 1 0", count_bit(9), count_bit(10), busy);
    end
  endtask

  task automatic test_async_reset();
    do_reset(); clear_stim();
    push(1, 0, 2);
    push_bits(1, 6'b011110, 2);
    push(1, 1, 2); push(1, 1, 2); push(1, 0, 2); push(1, 0, 2);
    push_bits(1, 6'b011110, 8);
    push(1, 1, 8); push(1, 1, 8); push(1, 0, 8);
    build_expected(); drive_all();
    for (int t = 0; t < obs_q.size(); t++) begin
      n_checks++;
      if (obs_q[t] !== exp_q[t]) begin
        n_fail++;
        $display("FAIL async_reset cycle %0d: got %b expected %b", t, obs_q[t], exp_q[t]);
      end
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, frame_done, serOutValid, serOut, frame_cnt} !== 12'h000) begin
      n_fail++;
      $display("FAIL async_reset outputs: got %b expected %b", {busy, frame_done, serOutValid, serOut, frame_cnt}, 12'h000);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset(); clear_stim();
    push(1, 0, 1);
    for (int f = 0; f < 260; f++) begin
      push_bits(1, 6'b011110, 1);
      push(1, 1'($urandom_range(0, 1)), 1);
      push(1, 0, 1); push(1, 0, 1);
    end
    push_bits(1, 6'b011100, 1);
    repeat (4) push(1, 0, 1);
    build_expected(); drive_all();
    for (int t = 0; t < obs_q.size(); t++) begin
      n_checks++;
      if (obs_q[t] !== exp_q[t]) begin
        n_fail++;
        $display("FAIL saturation cycle %0d: got %b expected %b", t, obs_q[t], exp_q[t]);
      end
    end
    n_checks++;
    if (frame_cnt !== 8'd255 || count_bit(10) != 260) begin
      n_fail++;
      $display("FAIL saturation count: got cnt %0d done %0d expected cnt 255 done 260", frame_cnt, count_bit(10));
    end
  endtask

  task automatic test_random();
    bit cur_en;
    do_reset(); clear_stim();
    cur_en = 1;
    while (din_q.size() < 3000) begin
      int fill;
      fill = $urandom_range(0, 4);
      for (int i = 0; i < fill; i++) begin
        if ($urandom_range(0, 39) == 0) cur_en = ~cur_en;
        push(cur_en, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      end
      if ($urandom_range(0, 39) == 0) cur_en = ~cur_en;
      push_bits(cur_en, ($urandom_range(0, 3) != 0) ? 6'b011110 : 6'b011100, 4'($urandom_range(0, 15)));
    end
    build_expected(); drive_all();
    for (int t = 0; t < obs_q.size(); t++) begin
      n_checks++;
      if (obs_q[t] !== exp_q[t]) begin
        n_fail++;
        $display("FAIL random cycle %0d: got %b expected %b", t, obs_q[t], exp_q[t]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_gap_pattern();
    test_zero_len();
    test_enable_drop();
    test_async_reset();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ser_frame_scheduler.md
SER_FRAME_SCHEDULER -- requirements
Module: ser_frame_scheduler

Interface
REQ-001 Parameter PAT_LEN, default 6, SHALL set the start-pattern length in bits (2..16).
REQ-002 Parameter PATTERN, default 6'b011110, SHALL set the start pattern; the MSB is the oldest bit received.
REQ-003 Parameter CNT_W, default 10, SHALL set the payload-counter width.
REQ-004 Parameter GAP_LEN, default 2, SHALL set the number of dead cycles after each frame (1..255).
REQ-005 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  SHALL be an asynchronous, active-high reset.
REQ-007 enable  in  1  arms pattern hunting while high.
REQ-008 serIn  in  1  serial data input, sampled every rising clk edge.
REQ-009 win_len  in  CNT_W  payload length in bits; 0 means 2^CNT_W.
REQ-010 serOut  out  1  registered payload bit; 0 when not valid.
REQ-011 serOutValid  out  1  registered; high while serOut carries payload.
REQ-012 busy  out  1  high in PAYLOAD or GAP.
REQ-013 frame_done  out  1  single-cycle pulse marking the last payload bit.
REQ-014 frame_cnt  out  8  count of completed frames, saturating.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, HUNT, PAYLOAD and GAP, encoded in 2 bits with no unreachable codes.
REQ-016 IDLE SHALL go to HUNT on the first edge with enable=1 and clear the PAT_LEN-bit history register.
REQ-017 In HUNT, the history register SHALL shift left by one bit each edge, taking serIn as its LSB.
REQ-018 In HUNT, a match SHALL occur when {history[PAT_LEN-2:0], serIn} == PATTERN at an edge, and SHALL cause a transition to PAYLOAD.
REQ-019 At the match edge, win_len SHALL be captured into the down-counter; changes to win_len during a frame SHALL have no effect.
REQ-020 PAYLOAD SHALL last exactly N edges (N = captured length); at each edge serOut<=serIn and serOutValid<=1.
REQ-021 The first payload bit SHALL be serIn at the first edge after the match; latency from serIn sample to serOut is 1 cycle.
REQ-022 On the Nth payload edge, frame_done<=1 and the FSM SHALL move to GAP; frame_done therefore coincides with the last valid serOut bit.
REQ-023 GAP SHALL last exactly GAP_LEN edges with serOutValid=0 and serOut=0, with no matching; it then SHALL go to HUNT with the history cleared, or to IDLE if enable=0.
REQ-024 enable falling in HUNT SHALL send the FSM to IDLE on that edge.
REQ-025 enable falling in PAYLOAD or GAP SHALL NOT truncate the frame: the frame completes, then the FSM goes to IDLE.
REQ-026 frame_cnt SHALL increment on each frame_done and hold at 255.
REQ-027 Bits received before or during a frame SHALL never contribute to a later match, so frames cannot overlap.
REQ-028 The counter SHALL be CNT_W bits wide; win_len=0 SHALL produce 2^CNT_W payload bits with no wrap-around error.
REQ-029 No combinational path SHALL exist from any input to any output.

Reset
REQ-030 rst=1 SHALL, asynchronously and at any point including mid-frame, force state=IDLE, history=0, counter=0, serOut=0, serOutValid=0, busy=0, frame_done=0 and frame_cnt=0.
REQ-031 The first edge after rst falls SHALL be evaluated as IDLE.

Verification
REQ-032 enable=1, win_len=4, serIn=0,1,1,1,1,0 then 1,0,1,1 -> serOutValid high for 4 cycles with serOut=1,0,1,1; frame_done on the 4th; frame_cnt=1.
REQ-033 Frame with GAP_LEN=2 followed immediately by the pattern starting in the first GAP cycle -> no match; the pattern sent after GAP detects normally.
REQ-034 CNT_W=4, win_len=0 -> exactly 16 valid bits, then one frame_done.
REQ-035 enable dropped in the 2nd payload cycle of win_len=8 -> all 8 bits output, then GAP, then IDLE; a later pattern is ignored.
REQ-036 rst asserted in the 3rd payload cycle -> all outputs are 0 immediately (before the next edge); frame_cnt=0.
REQ-037 256+ frames -> frame_cnt holds 255; the near-miss 011100 -> no match.
